// File: rtl/xy2_100_rx_multi.sv
// Multi-channel XY2-100 feedback receiver.
// Each serial line gets its own synchroniser, framing FSM, majority
// sampler and parity checker; channels never interact.
module xy2_100_rx_multi #(
    parameter int CH_NUM     = 2,
    parameter int DATA_W     = 16,
    parameter int BIT_CLKS   = 20,
    parameter int SAMPLE_POS = 11,
    parameter int PARITY_ODD = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_en,
    input  logic [CH_NUM-1:0]        feed_back,
    output logic [CH_NUM-1:0]        feed_back_data_valid,
    output logic [CH_NUM*DATA_W-1:0] feed_back_data,
    output logic [CH_NUM-1:0]        parity_err,
    output logic [CH_NUM-1:0]        frame_err,
    output logic [CH_NUM-1:0]        busy
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] SMP_EARLY = CW'(SAMPLE_POS - 1);
    localparam logic [CW-1:0] SMP_MID = CW'(SAMPLE_POS);
    localparam logic [CW-1:0] SMP_DECIDE = CW'(SAMPLE_POS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        PAR
    } state_t;

    genvar ch;
    generate
        for (ch = 0; ch < CH_NUM; ch++) begin : g_ch
            logic s1, s2, s3;
            logic rise;
            state_t state, state_nxt;
            logic [CW-1:0] period_cnt;
            logic [BW-1:0] bit_cnt;
            logic [1:0] samp;
            logic [DATA_W-1:0] shadow;
            logic [DATA_W-1:0] data_q;
            logic par_acc;
            logic at_last, at_decide;
            logic maj;
            logic take_bit, frame_good, frame_bad_par, frame_bad_pre;
            logic valid_q, perr_q, ferr_q, busy_q;

            assign rise      = s2 & ~s3;
            assign at_last   = (period_cnt == CNT_LAST);
            assign at_decide = (period_cnt == SMP_DECIDE);

            // Two-stage synchroniser plus a history stage for edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                    s3 <= 1'b0;
                end else begin
                    s1 <= feed_back[ch];
                    s2 <= s1;
                    s3 <= s2;
                end
            end

            // Framing state register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= IDLE;
                end else begin
                    state <= state_nxt;
                end
            end

            // Frame sequencing; dropping the enable abandons any frame in flight
            always_comb begin
                state_nxt = state;
                if (!rx_en) begin
                    state_nxt = IDLE;
                end else begin
                    case (state)
                        IDLE: if (rise) state_nxt = PRE;
                        PRE: begin
                            if (at_decide && !maj) begin
                                state_nxt = IDLE;
                            end else if (at_last) begin
                                state_nxt = DATA;
                            end
                        end
                        DATA: if (at_last && bit_cnt == BIT_LAST) state_nxt = PAR;
                        PAR: if (at_last) state_nxt = IDLE;
                        default: state_nxt = IDLE;
                    endcase
                end
            end

            // Majority vote and per-bit decisions, all gated by the enable
            always_comb begin
                maj           = (samp[1] & samp[0]) | (samp[1] & s2) | (samp[0] & s2);
                take_bit      = 1'b0;
                frame_good    = 1'b0;
                frame_bad_par = 1'b0;
                frame_bad_pre = 1'b0;
                if (rx_en && at_decide) begin
                    case (state)
                        PRE:  frame_bad_pre = ~maj;
                        DATA: take_bit = 1'b1;
                        PAR: begin
                            frame_good    = ((par_acc ^ maj) == PAR_SENSE);
                            frame_bad_par = ((par_acc ^ maj) != PAR_SENSE);
                        end
                        default: ;
                    endcase
                end
            end

            // Bit timing counters, sample capture, shift register and parity accumulator
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    period_cnt <= '0;
                    bit_cnt    <= '0;
                    samp       <= '0;
                    shadow     <= '0;
                    par_acc    <= 1'b0;
                end else begin
                    if (state == IDLE || state_nxt == IDLE || at_last) begin
                        period_cnt <= '0;
                    end else begin
                        period_cnt <= period_cnt + CW'(1);
                    end

                    if (state != DATA || state_nxt != DATA) begin
                        bit_cnt <= '0;
                    end else if (at_last) begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end

                    if (state != IDLE) begin
                        if (period_cnt == SMP_EARLY) samp[0] <= s2;
                        if (period_cnt == SMP_MID) samp[1] <= s2;
                    end

                    if (state == IDLE && state_nxt == PRE) begin
                        par_acc <= 1'b0;
                    end else if (take_bit) begin
                        par_acc <= par_acc ^ maj;
                    end

                    if (take_bit) begin
                        shadow <= {shadow[DATA_W-2:0], maj};
                    end
                end
            end

            // Registered result word, single-cycle status pulses and busy flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    if (frame_good) data_q <= shadow;
                    valid_q <= frame_good;
                    perr_q  <= frame_bad_par;
                    ferr_q  <= frame_bad_pre;
                    busy_q  <= (state != IDLE);
                end
            end

            assign feed_back_data_valid[ch]           = valid_q;
            assign feed_back_data[ch*DATA_W +: DATA_W] = data_q;
            assign parity_err[ch]                     = perr_q;
            assign frame_err[ch]                      = ferr_q;
            assign busy[ch]                           = busy_q;
        end
    endgenerate

endmodule

// File: tb/tb_xy2_100_rx_multi.sv
// Scoreboard bench for xy2_100_rx_multi: a standard 16-bit instance and an
// extended 18-bit / 10-clock instance are driven with directed and random
// frames; expected results and their arrival cycles come from the frame
// timing rules, and a monitor pops them as the receivers report.
module tb_xy2_100_rx_multi;

    localparam int DW [2] = '{16, 18};
    localparam int BC [2] = '{20, 10};
    localparam int SP [2] = '{11, 5};

    typedef struct {
        int          kind;
        logic [19:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_en_a, rx_en_b;
    logic [1:0]  fb_a, fb_b;
    logic [1:0]  valid_a, perr_a, ferr_a, busy_a;
    logic [1:0]  valid_b, perr_b, ferr_b, busy_b;
    logic [31:0] data_a;
    logic [35:0] data_b;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq [4][$];
    logic [19:0] last_data [4];

    xy2_100_rx_multi #(
        .CH_NUM(2), .DATA_W(16), .BIT_CLKS(20), .SAMPLE_POS(11), .PARITY_ODD(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en_a), .feed_back(fb_a),
        .feed_back_data_valid(valid_a), .feed_back_data(data_a),
        .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
    );

    xy2_100_rx_multi #(
        .CH_NUM(2), .DATA_W(18), .BIT_CLKS(10), .SAMPLE_POS(5), .PARITY_ODD(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en_b), .feed_back(fb_b),
        .feed_back_data_valid(valid_b), .feed_back_data(data_b),
        .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter: at each falling edge it equals the number of rising edges seen
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [19:0] data_mask(input int d);
        return 20'((1 << DW[d]) - 1);
    endfunction

    // Parity bit that makes XOR(data, parity) equal 1
    function automatic logic odd_par(input int d, input logic [19:0] data);
        return ~(^(data & data_mask(d)));
    endfunction

    task automatic set_line(input int d, input int ch, input logic v);
        if (d == 0) fb_a[ch] = v;
        else fb_b[ch] = v;
    endtask

    // Drive one frame (preamble, data MSB first, parity) then two bit times low
    task automatic apply_stimulus(input int d, input int ch, input logic [19:0] data,
                                  input logic par, input bit spike, input bit expect_it);
        exp_t e;
        logic v;
        int   bt = BC[d];
        @(negedge clk);
        if (expect_it) begin
            e.data = data & data_mask(d);
            e.kind = ((^e.data) ^ par) ? 0 : 1;
            e.cyc  = cyc + 3 + (DW[d] + 1) * bt + SP[d] + 2;
            sbq[d*2+ch].push_back(e);
        end
        for (int b = 0; b < DW[d] + 2; b++) begin
            for (int j = 0; j < bt; j++) begin
                if (b != 0 || j != 0) @(negedge clk);
                if (b == 0) v = 1'b1;
                else if (b <= DW[d]) v = data[DW[d]-b];
                else v = par;
                if (spike && b >= 1 && b <= DW[d] && j == SP[d] + 1) v = ~v;
                set_line(d, ch, v);
            end
        end
        for (int j = 0; j < 2 * bt; j++) begin
            @(negedge clk);
            set_line(d, ch, 1'b0);
        end
    endtask

    // Short high pulse from idle: preamble must be rejected
    task automatic apply_glitch(input int d, input int ch);
        exp_t e;
        @(negedge clk);
        e.kind = 2;
        e.data = '0;
        e.cyc  = cyc + 3 + SP[d] + 2;
        sbq[d*2+ch].push_back(e);
        for (int j = 0; j < 4 + 2 * BC[d]; j++) begin
            if (j != 0) @(negedge clk);
            set_line(d, ch, (j < 4) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic random_stream(input int d, input int ch, input int frames);
        logic [19:0] data;
        logic        par;
        for (int i = 0; i < frames; i++) begin
            repeat ($urandom_range(0, 3 * BC[d])) @(negedge clk);
            data = 20'($urandom) & data_mask(d);
            par  = odd_par(d, data) ^ ($urandom_range(0, 3) == 0);
            apply_stimulus(d, ch, data, par, ($urandom_range(0, 3) == 0), 1'b1);
        end
    endtask

    // Monitor: pop the scoreboard whenever a channel reports, flag missed results
    always @(negedge clk) begin
        logic [2:0]  pulses, exp_p;
        logic [19:0] dat;
        exp_t        e;
        int          q;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                q = d * 2 + ch;
                if (d == 0) begin
                    pulses = {valid_a[ch], perr_a[ch], ferr_a[ch]};
                    dat    = 20'(data_a[ch*16 +: 16]);
                end else begin
                    pulses = {valid_b[ch], perr_b[ch], ferr_b[ch]};
                    dat    = 20'(data_b[ch*18 +: 18]);
                end
                if (pulses != 3'b000) begin
                    if (sbq[q].size() == 0) begin
                        check_output($sformatf("unexpected_pulse_d%0d_ch%0d", d, ch), 40'(pulses), 40'd0);
                    end else begin
                        e = sbq[q].pop_front();
                        exp_p = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
                        check_output($sformatf("pulse_kind_d%0d_ch%0d", d, ch), 40'(pulses), 40'(exp_p));
                        check_output($sformatf("pulse_cycle_d%0d_ch%0d", d, ch), 40'(cyc), 40'(e.cyc));
                        if (e.kind == 0) begin
                            check_output($sformatf("data_d%0d_ch%0d", d, ch), 40'(dat), 40'(e.data));
                            last_data[q] = e.data;
                        end else if (e.kind == 1) begin
                            check_output($sformatf("data_hold_d%0d_ch%0d", d, ch), 40'(dat), 40'(last_data[q]));
                        end
                    end
                end else if (sbq[q].size() != 0 && cyc > sbq[q][0].cyc) begin
                    e = sbq[q].pop_front();
                    check_output($sformatf("missed_pulse_d%0d_ch%0d", d, ch), 40'(cyc - 1), 40'(e.cyc));
                end
            end
        end
    end

    // Global time bound
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test plan followed by randomized traffic on all four channels
    initial begin
        int t0;
        int w;
        for (int q = 0; q < 4; q++) last_data[q] = '0;
        rst_n = 1'b0;
        rx_en_a = 1'b1;
        rx_en_b = 1'b1;
        fb_a = 2'b00;
        fb_b = 2'b00;
        repeat (4) @(negedge clk);
        check_output("reset_data_a", 40'(data_a), 40'd0);
        check_output("reset_data_b", 40'(data_b), 40'd0);
        check_output("reset_flags", 40'({valid_a, perr_a, ferr_a, busy_a, valid_b, perr_b, ferr_b, busy_b}), 40'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] good frame 0xA5C3 on ch0 with busy timing");
        fork
            apply_stimulus(0, 0, 20'h0A5C3, odd_par(0, 20'h0A5C3), 1'b0, 1'b1);
            begin
                @(negedge clk);
                t0 = cyc;
                repeat (3) @(negedge clk);
                check_output("busy_at_E", 40'(busy_a[0]), 40'd0);
                @(negedge clk);
                check_output("busy_at_E+1", 40'(busy_a[0]), 40'd1);
                while (cyc < t0 + 3 + 360) @(negedge clk);
                check_output("busy_at_E+360", 40'(busy_a[0]), 40'd1);
                @(negedge clk);
                check_output("busy_at_E+361", 40'(busy_a[0]), 40'd0);
            end
        join

        $display("[TB] simultaneous frames on both channels of both instances");
        fork
            apply_stimulus(0, 0, 20'h01234, odd_par(0, 20'h01234), 1'b0, 1'b1);
            apply_stimulus(0, 1, 20'h0BEEF, odd_par(0, 20'h0BEEF), 1'b0, 1'b1);
            apply_stimulus(1, 0, 20'h2ABCD, odd_par(1, 20'h2ABCD), 1'b0, 1'b1);
            apply_stimulus(1, 1, 20'h15432, odd_par(1, 20'h15432), 1'b0, 1'b1);
        join

        $display("[TB] wrong parity on ch1");
        apply_stimulus(0, 1, 20'h00001, 1'b1, 1'b0, 1'b1);

        $display("[TB] glitch on ch0 of both instances");
        fork
            apply_glitch(0, 0);
            apply_glitch(1, 0);
        join

        $display("[TB] mid-bit spikes on 0xFFFF");
        apply_stimulus(0, 0, 20'h0FFFF, odd_par(0, 20'h0FFFF), 1'b1, 1'b1);

        $display("[TB] enable dropped at data bit 8");
        fork
            apply_stimulus(0, 0, 20'h05A5A, odd_par(0, 20'h05A5A), 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (9 * 20) @(negedge clk);
                rx_en_a = 1'b0;
                repeat (3) @(negedge clk);
                check_output("busy_after_disable", 40'(busy_a[0]), 40'd0);
            end
        join
        rx_en_a = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] reset asserted mid-frame");
        fork
            apply_stimulus(0, 0, 20'h0C0DE, odd_par(0, 20'h0C0DE), 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (100) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check_output("reset_mid_busy", 40'({busy_a, busy_b}), 40'd0);
                check_output("reset_mid_data_a", 40'(data_a), 40'd0);
                check_output("reset_mid_data_b", 40'(data_b), 40'd0);
            end
        join
        for (int q = 0; q < 4; q++) last_data[q] = '0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] randomized traffic");
        fork
            random_stream(0, 0, 8);
            random_stream(0, 1, 8);
            random_stream(1, 0, 12);
            random_stream(1, 1, 12);
        join

        w = 0;
        while (w < 1000 && (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0) begin
            @(negedge clk);
            w++;
        end
        for (int q = 0; q < 4; q++) begin
            check_output($sformatf("scoreboard_empty_q%0d", q), 40'(sbq[q].size()), 40'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
